// File: rtl/cntr8_fsm_pkg.sv
// Shared state-code definitions for the counter FSM and its downstream output-logic stage.
package cntr8_fsm_pkg;

  localparam logic [2:0] StIdle = 3'b000;
  localparam logic [2:0] StLoad = 3'b001;
  localparam logic [2:0] StInc  = 3'b010;
  localparam logic [2:0] StInc2 = 3'b011;
  localparam logic [2:0] StDec  = 3'b100;
  localparam logic [2:0] StDec2 = 3'b101;

  function automatic logic is_up(input logic [2:0] st);
    return (st == StInc) || (st == StInc2);
  endfunction

  function automatic logic is_down(input logic [2:0] st);
    return (st == StDec) || (st == StDec2);
  endfunction

endpackage

// File: rtl/cntr8_ns_logic.sv
// Combinational next-state logic for cntr8_fsm.
module cntr8_ns_logic
  import cntr8_fsm_pkg::*;
(
  input  logic [2:0] state,
  input  logic       load,
  input  logic       en,
  input  logic       inc,
  output logic [2:0] state_next
);

  always_comb begin
    state_next = StIdle;
    if (load) begin
      state_next = StLoad;
    end else if (!en) begin
      state_next = StIdle;
    end else if (state == 3'b110 || state == 3'b111) begin
      // Illegal codes recover to IDLE.
      state_next = StIdle;
    end else if (inc) begin
      state_next = (state == StInc) ? StInc2 : StInc;
    end else begin
      state_next = (state == StDec) ? StDec2 : StDec;
    end
  end

endmodule

// File: rtl/cntr8_fsm.sv
// Up/down counter FSM: state, count and wrap registers; count arithmetic lives downstream.
module cntr8_fsm
  import cntr8_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic       inc,
  input  logic [7:0] cnt_nxt,
  output logic [2:0] state,
  output logic [7:0] cnt,
  output logic       wrap
);

  logic [2:0] state_d, state_q;
  logic [7:0] cnt_d, cnt_q;
  logic       wrap_d, wrap_q;

  cntr8_ns_logic u_ns_logic (
    .state      (state_q),
    .load       (load),
    .en         (en),
    .inc        (inc),
    .state_next (state_d)
  );

  always_comb begin
    cnt_d  = cnt_nxt;
    // Wrap is judged on the direction of the current state, not the next one.
    wrap_d = (is_up(state_q)   && (cnt_q == 8'hFF) && (cnt_nxt == 8'h00)) ||
             (is_down(state_q) && (cnt_q == 8'h00) && (cnt_nxt == 8'hFF));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'h00;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign state = state_q;
  assign cnt   = cnt_q;
  assign wrap  = wrap_q;

endmodule
